// File: rtl/ahb_slave_arbiter_rr.sv
// Per-slave AHB arbiter for NUM_MST masters: highest priority wins, round-robin
// among equals, grant locked for the length of fixed-length bursts.
module ahb_slave_arbiter_rr #(
  parameter int NUM_MST   = 4,
  parameter int PRIO_W    = 2,
  parameter int MST_IDX_W = (NUM_MST > 1) ? $clog2(NUM_MST) : 1
) (
  input  logic                      hclk,
  input  logic                      hreset,
  input  logic [NUM_MST-1:0]        hreq,
  input  logic [NUM_MST*PRIO_W-1:0] hprior,
  input  logic [1:0]                htrans,
  input  logic [2:0]                hburst,
  input  logic                      hready,
  output logic [NUM_MST-1:0]        hgrant,
  output logic [NUM_MST-1:0]        hgrant_data,
  output logic [MST_IDX_W-1:0]      hmaster,
  output logic                      hsel
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  typedef enum logic [1:0] {IDLE, OWN, BURST} state_t;

  state_t                 state;
  logic [3:0]             beat_cnt;
  logic [MST_IDX_W-1:0]   rr_ptr;

  logic                   acc;
  logic [3:0]             burst_len_m1;
  logic                   fixed_burst;
  logic                   rearb;
  logic [PRIO_W-1:0]      max_prio;
  logic [NUM_MST-1:0]     cand;
  logic                   win_found;
  logic [MST_IDX_W-1:0]   win_idx;
  logic [NUM_MST-1:0]     win_onehot;
  logic [MST_IDX_W-1:0]   next_ptr;
  logic                   owner_change;

  assign hsel = (|hgrant) & htrans[1];
  assign acc  = hsel & hready;

  // Remaining beats after the NONSEQ; zero marks SINGLE/INCR (no lock).
  always_comb begin
    burst_len_m1 = 4'd0;
    case (hburst)
      3'd2, 3'd3: burst_len_m1 = 4'd3;
      3'd4, 3'd5: burst_len_m1 = 4'd7;
      3'd6, 3'd7: burst_len_m1 = 4'd15;
      default:    burst_len_m1 = 4'd0;
    endcase
  end
  assign fixed_burst = (burst_len_m1 != 4'd0);

  // Candidates are the requesters at the top priority; the winner is the first
  // one at or above rr_ptr, otherwise the lowest-indexed one (wrap-around).
  always_comb begin
    max_prio   = '0;
    cand       = '0;
    win_found  = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      if (hreq[i] && (hprior[i*PRIO_W +: PRIO_W] > max_prio))
        max_prio = hprior[i*PRIO_W +: PRIO_W];
    end
    for (int i = 0; i < NUM_MST; i++)
      cand[i] = hreq[i] && (hprior[i*PRIO_W +: PRIO_W] == max_prio);
    for (int i = 0; i < NUM_MST; i++) begin
      if (!win_found && cand[i] && (i >= int'(rr_ptr))) begin
        win_found     = 1'b1;
        win_idx       = i[MST_IDX_W-1:0];
        win_onehot[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_MST; i++) begin
      if (!win_found && cand[i]) begin
        win_found     = 1'b1;
        win_idx       = i[MST_IDX_W-1:0];
        win_onehot[i] = 1'b1;
      end
    end
  end

  assign next_ptr     = (int'(win_idx) == NUM_MST - 1) ? '0 : win_idx + 1'b1;
  assign owner_change = ~(|hgrant) || (win_idx != hmaster);

  always_comb begin
    rearb = 1'b0;
    case (state)
      IDLE:  rearb = hready && (|hreq);
      OWN:   rearb = (acc && (htrans == TR_NONSEQ) && !fixed_burst) ||
                     (hready && (htrans == TR_IDLE));
      BURST: rearb = (acc && (htrans == TR_SEQ) && (beat_cnt == 4'd1)) ||
                     (hready && ((htrans == TR_IDLE) || (htrans == TR_NONSEQ)));
      default: rearb = 1'b0;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state       <= IDLE;
      hgrant      <= '0;
      hgrant_data <= '0;
      hmaster     <= '0;
      beat_cnt    <= '0;
      rr_ptr      <= '0;
    end else begin
      if (hready)
        hgrant_data <= hgrant;
      if (rearb) begin
        beat_cnt <= '0;
        if (win_found) begin
          state   <= OWN;
          hgrant  <= win_onehot;
          hmaster <= win_idx;
          if (owner_change)
            rr_ptr <= next_ptr;
        end else begin
          state   <= IDLE;
          hgrant  <= '0;
          hmaster <= '0;
        end
      end else if ((state == OWN) && acc && (htrans == TR_NONSEQ) && fixed_burst) begin
        state    <= BURST;
        beat_cnt <= burst_len_m1;
      end else if ((state == BURST) && acc && (htrans == TR_SEQ)) begin
        beat_cnt <= beat_cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_ahb_slave_arbiter_rr.sv
// Randomised and directed bench for ahb_slave_arbiter_rr (4 masters, 2-bit
// priority) checked by a scoreboard fed from a rule-level reference model.
module tb_ahb_slave_arbiter_rr;

  localparam int N = 4;
  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NONSEQ = 2'b10, T_SEQ = 2'b11;
  localparam logic [2:0] B_SINGLE = 3'd0, B_INCR4 = 3'd3, B_WRAP8 = 3'd4, B_INCR8 = 3'd5;

  // clock / reset
  logic       clk = 1'b0;
  logic       hreset;
  logic [3:0] hreq;
  logic [7:0] hprior;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic       hready;
  logic [3:0] hgrant, hgrant_data;
  logic [1:0] hmaster;
  logic       hsel;

  always #5 clk = ~clk;

  ahb_slave_arbiter_rr #(.NUM_MST(4), .PRIO_W(2)) dut (
    .hclk(clk), .hreset(hreset), .hreq(hreq), .hprior(hprior),
    .htrans(htrans), .hburst(hburst), .hready(hready),
    .hgrant(hgrant), .hgrant_data(hgrant_data), .hmaster(hmaster), .hsel(hsel)
  );

  int checks = 0;
  int errors = 0;

  // expected {hsel, hmaster, hgrant_data, hgrant}
  logic [10:0] exp_q[$];

  // reference model: owner/data owner as indices, -1 meaning none
  int m_owner = -1;
  int m_data  = -1;
  int m_ptr   = 0;
  int m_left  = 0;
  bit m_locked = 0;

  function automatic logic [3:0] vec_of(input int idx);
    logic [3:0] v;
    v = 4'b0000;
    if (idx >= 0) v[idx] = 1'b1;
    return v;
  endfunction

  function automatic int arbitrate(input logic [3:0] req, input logic [7:0] pri);
    int best;
    int w;
    int j;
    best = -1;
    w = -1;
    for (int i = 0; i < N; i++)
      if (req[i] && int'(pri[i*2 +: 2]) > best) best = int'(pri[i*2 +: 2]);
    for (int k = 0; k < N; k++) begin
      j = (m_ptr + k) % N;
      if (w < 0 && req[j] && int'(pri[j*2 +: 2]) == best) w = j;
    end
    return w;
  endfunction

  task automatic model_step(input logic rst, input logic [3:0] req, input logic [7:0] pri,
                            input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
    bit acc;
    bit re;
    int w;
    if (rst) begin
      m_owner = -1; m_data = -1; m_ptr = 0; m_left = 0; m_locked = 0;
      return;
    end
    acc = (m_owner >= 0) && tr[1] && rdy;
    re = 0;
    if (m_owner < 0) begin
      re = rdy && (req != 4'b0);
    end else if (!m_locked) begin
      if (acc && tr == T_NONSEQ && bu >= 3'd2) begin
        m_locked = 1;
        m_left = (4 << ((int'(bu) >> 1) - 1)) - 1;
      end else if ((acc && tr == T_NONSEQ) || (rdy && tr == T_IDLE)) begin
        re = 1;
      end
    end else begin
      if (rdy && (tr == T_IDLE || tr == T_NONSEQ)) re = 1;
      else if (acc && tr == T_SEQ) begin
        m_left--;
        if (m_left == 0) re = 1;
      end
    end
    if (rdy) m_data = m_owner;
    if (re) begin
      w = arbitrate(req, pri);
      m_locked = 0;
      if (w >= 0 && w != m_owner) m_ptr = (w + 1) % N;
      m_owner = w;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", name, got, exp, $time);
    end
  endtask

  // driver: apply one cycle of inputs, queue the expected outputs, advance model
  task automatic drive(input logic rst, input logic [3:0] req, input logic [7:0] pri,
                       input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
    logic [1:0] mi;
    hreset = rst; hreq = req; hprior = pri; htrans = tr; hburst = bu; hready = rdy;
    mi = (m_owner < 0) ? 2'd0 : 2'(m_owner);
    exp_q.push_back({(m_owner >= 0) && tr[1], mi, vec_of(m_data), vec_of(m_owner)});
    @(posedge clk);
    model_step(rst, req, pri, tr, bu, rdy);
    #1;
  endtask

  // monitor: compares every cycle at the falling edge
  always @(negedge clk) begin
    logic [10:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_hgrant", {28'd0, hgrant}, {28'd0, e[3:0]});
      chk("sb_hgrant_data", {28'd0, hgrant_data}, {28'd0, e[7:4]});
      chk("sb_hmaster", {30'd0, hmaster}, {30'd0, e[9:8]});
      chk("sb_hsel", {31'd0, hsel}, {31'd0, e[10]});
      chk("sb_onehot", {31'd0, $onehot0(hgrant) && $onehot0(hgrant_data)}, 32'd1);
    end
  end

  logic [3:0] rr_exp [4];

  initial begin
    logic [1:0] tr;
    int r;
    rr_exp[0] = 4'b0010; rr_exp[1] = 4'b0100; rr_exp[2] = 4'b1000; rr_exp[3] = 4'b0001;
    hreset = 1'b1; hreq = '0; hprior = '0; htrans = T_IDLE; hburst = B_SINGLE; hready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    drive(1, 4'b0000, 8'h00, T_IDLE, B_SINGLE, 1);
    chk("rst_hgrant", {28'd0, hgrant}, 32'd0);
    chk("rst_hgrant_data", {28'd0, hgrant_data}, 32'd0);
    chk("rst_hmaster", {30'd0, hmaster}, 32'd0);
    chk("rst_hsel", {31'd0, hsel}, 32'd0);

    // priority: m1 prio 1, m3 prio 3
    drive(0, 4'b1010, 8'hC4, T_IDLE, B_SINGLE, 1);
    chk("prio_hgrant", {28'd0, hgrant}, 32'h8);
    chk("prio_hmaster", {30'd0, hmaster}, 32'd3);
    drive(0, 4'b0000, 8'h00, T_IDLE, B_SINGLE, 1);
    chk("release_hgrant", {28'd0, hgrant}, 32'd0);

    // round-robin with equal priorities
    drive(0, 4'b1111, 8'h00, T_IDLE, B_SINGLE, 1);
    chk("rr_first", {28'd0, hgrant}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      drive(0, 4'b1111, 8'h00, T_NONSEQ, B_SINGLE, 1);
      chk("rr_seq", {28'd0, hgrant}, {28'd0, rr_exp[i]});
    end
    drive(0, 4'b0000, 8'h00, T_IDLE, B_SINGLE, 1);

    // INCR4 lock against a higher-priority m2
    drive(0, 4'b0001, 8'h00, T_IDLE, B_SINGLE, 1);
    chk("lock_own", {28'd0, hgrant}, 32'h1);
    drive(0, 4'b0101, 8'h30, T_NONSEQ, B_INCR4, 1);
    chk("lock_b1", {28'd0, hgrant}, 32'h1);
    for (int i = 0; i < 2; i++) begin
      drive(0, 4'b0101, 8'h30, T_SEQ, B_INCR4, 1);
      chk("lock_mid", {28'd0, hgrant}, 32'h1);
    end
    drive(0, 4'b0101, 8'h30, T_SEQ, B_INCR4, 1);
    chk("lock_handover", {28'd0, hgrant}, 32'h4);
    chk("lock_hmaster", {30'd0, hmaster}, 32'd2);

    // wait states during a handover
    for (int i = 0; i < 3; i++) begin
      drive(0, 4'b0010, 8'h00, T_IDLE, B_SINGLE, 0);
      chk("wait_hgrant", {28'd0, hgrant}, 32'h4);
      chk("wait_hgrant_data", {28'd0, hgrant_data}, 32'h1);
    end
    drive(0, 4'b0010, 8'h00, T_IDLE, B_SINGLE, 1);
    chk("wait_new_grant", {28'd0, hgrant}, 32'h2);
    chk("wait_data_lag", {28'd0, hgrant_data}, 32'h4);
    drive(0, 4'b0010, 8'h00, T_IDLE, B_SINGLE, 1);
    chk("wait_data_follow", {28'd0, hgrant_data}, 32'h2);

    // full WRAP8 with a BUSY after beat 2: lock lasts all 8 beats
    drive(0, 4'b1010, 8'h00, T_NONSEQ, B_WRAP8, 1);
    drive(0, 4'b1010, 8'h00, T_SEQ, B_WRAP8, 1);
    drive(0, 4'b1010, 8'h00, T_BUSY, B_WRAP8, 1);
    for (int i = 0; i < 5; i++) begin
      drive(0, 4'b1010, 8'h00, T_SEQ, B_WRAP8, 1);
      chk("busy_hold", {28'd0, hgrant}, 32'h2);
    end
    drive(0, 4'b1010, 8'h00, T_SEQ, B_WRAP8, 1);
    chk("wrap8_end", {28'd0, hgrant}, 32'h8);

    // WRAP8 terminated early by IDLE after beat 5
    drive(0, 4'b1001, 8'h00, T_NONSEQ, B_WRAP8, 1);
    drive(0, 4'b1001, 8'h00, T_SEQ, B_WRAP8, 1);
    drive(0, 4'b1001, 8'h00, T_BUSY, B_WRAP8, 1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 4'b1001, 8'h00, T_SEQ, B_WRAP8, 1);
      chk("early_hold", {28'd0, hgrant}, 32'h8);
    end
    drive(0, 4'b1001, 8'h00, T_IDLE, B_WRAP8, 1);
    chk("early_handover", {28'd0, hgrant}, 32'h1);

    // reset in the middle of an INCR8
    drive(0, 4'b0001, 8'h00, T_NONSEQ, B_INCR8, 1);
    drive(0, 4'b0001, 8'h00, T_SEQ, B_INCR8, 1);
    drive(1, 4'b0001, 8'h00, T_SEQ, B_INCR8, 1);
    drive(1, 4'b0001, 8'h00, T_SEQ, B_INCR8, 1);
    chk("midrst_hgrant", {28'd0, hgrant}, 32'd0);
    chk("midrst_hgrant_data", {28'd0, hgrant_data}, 32'd0);
    chk("midrst_hsel", {31'd0, hsel}, 32'd0);
    drive(0, 4'b0000, 8'h00, T_IDLE, B_SINGLE, 1);

    // random traffic
    for (int n = 0; n < 800; n++) begin
      r = $urandom_range(0, 99);
      tr = (r < 40) ? T_SEQ : (r < 65) ? T_NONSEQ : (r < 85) ? T_IDLE : T_BUSY;
      drive(($urandom_range(0, 63) == 0), 4'($urandom_range(0, 15)), 8'($urandom),
            tr, 3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d left exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL timeout got no finish exp finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
